// File: rtl/leaf_router.sv
// Five-port leaf switch: four NI ports plus one uplink, with a FIFO per input,
// round-robin arbitration per output and registered outputs.

module leaf_router_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              not_empty,
    output logic              ready,
    output logic              overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL      = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(FIFO_DEPTH - 2);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       count;
    logic              do_push, do_pop;

    assign not_empty = (count != '0);
    assign head      = mem[rd_ptr];
    // Two free slots cover the flit that may already be in flight behind ready.
    assign ready     = (count <= READY_MAX);
    assign overflow  = push && (count == FULL);
    assign do_push   = push && !overflow;
    assign do_pop    = pop && not_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module leaf_router #(
    parameter int GROUP_ID   = 1,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int NPORTS     = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS*DATA_W-1:0] in_data,
    input  logic [NPORTS-1:0]        in_valid,
    output logic [NPORTS-1:0]        in_ready,
    output logic [NPORTS*DATA_W-1:0] out_data,
    output logic [NPORTS-1:0]        out_valid,
    input  logic [NPORTS-1:0]        out_ready,
    output logic [7:0]               drop_count
);
    logic [NPORTS-1:0][DATA_W-1:0] head;
    logic [NPORTS-1:0][DATA_W-1:0] out_q;
    logic [NPORTS-1:0][2:0]        target;
    logic [NPORTS-1:0][2:0]        ptr;
    logic [NPORTS-1:0][2:0]        grant_src;
    logic [NPORTS-1:0]             not_empty, overflow, route_drop, req, pop, grant_vld;
    logic [2:0]                    cand;
    logic [3:0]                    ndrops;
    logic [8:0]                    drop_sum;

    function automatic logic [2:0] wrap(input int a);
        return 3'(a >= NPORTS ? a - NPORTS : a);
    endfunction

    for (genvar k = 0; k < NPORTS; k++) begin : g_in
        logic [5:0] hdr;
        logic       local_hit;

        leaf_router_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (in_valid[k]),
            .push_data (in_data[k*DATA_W +: DATA_W]),
            .pop       (pop[k]),
            .head      (head[k]),
            .not_empty (not_empty[k]),
            .ready     (in_ready[k]),
            .overflow  (overflow[k])
        );

        assign hdr       = head[k][DATA_W-1 -: 6];
        assign local_hit = (hdr[5:2] == GROUP_ID[3:0]);
        assign target[k] = local_hit ? {1'b0, hdr[1:0]} : 3'd4;
        // Null headers, and foreign groups arriving from the uplink, are discarded.
        assign route_drop[k] = not_empty[k] && ((hdr == 6'd0) || (!local_hit && k == NPORTS-1));
        assign req[k]        = not_empty[k] && !route_drop[k];
    end

    always_comb begin
        pop       = route_drop;
        cand      = '0;
        grant_vld = '0;
        grant_src = '0;
        for (int o = 0; o < NPORTS; o++) begin
            if (!out_valid[o] || out_ready[o]) begin
                for (int i = 0; i < NPORTS; i++) begin
                    cand = wrap(int'(ptr[o]) + i);
                    if (!grant_vld[o] && req[cand] && target[cand] == 3'(o)) begin
                        grant_vld[o] = 1'b1;
                        grant_src[o] = cand;
                    end
                end
                if (grant_vld[o])
                    pop[grant_src[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        ndrops = '0;
        for (int k = 0; k < NPORTS; k++)
            ndrops = ndrops + 4'(route_drop[k]) + 4'(overflow[k]);
        drop_sum = {1'b0, drop_count} + 9'(ndrops);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= '0;
            out_q      <= '0;
            ptr        <= '0;
            drop_count <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (!out_valid[o] || out_ready[o]) begin
                    out_valid[o] <= grant_vld[o];
                    if (grant_vld[o]) begin
                        out_q[o] <= head[grant_src[o]];
                        ptr[o]   <= wrap(int'(grant_src[o]) + 1);
                    end
                end
            end
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign out_data = out_q;
endmodule
